seq_det_prog: RTL and testbench

- Programmable serial sequence detector. It is the parametrised successor to the fixed 7-bit flag detector.
- Detects a run-time-loaded pattern of 1..MAX_LEN bits on a qualified serial stream. Each pattern bit can be masked as don't-care.
- Supports overlapping and non-overlapping match modes.
- Sits on the serial receive path and feeds frame-delimit logic with a one-cycle match pulse.

---
 rtl/seq_det_prog_if.sv | 57 +++++
 rtl/seq_det_prog.sv | 126 ++++++++++++
 tb/tb_seq_det_prog.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_prog_if
// Brief    : Configuration and serial-stream bundle for seq_det_prog.
//            Counter signals exist only when SEQDET_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

interface seq_det_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
`ifdef SEQDET_CNT_EN
    ,
    parameter int CNT_W   = 8
`endif
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [MAX_LEN-1:0] cfg_mask;
    logic [LEN_W-1:0]   cfg_len;
    logic               overlap;
    logic               ser_valid;
    logic               ser_in;
    logic               seq_valid;

`ifdef SEQDET_CNT_EN
    logic               cnt_clr;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output cfg_load, cfg_pattern, cfg_mask, cfg_len, overlap,
        output ser_valid, ser_in, cnt_clr,
        input  seq_valid, match_cnt
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_mask, cfg_len, overlap,
        input  ser_valid, ser_in, cnt_clr,
        output seq_valid, match_cnt
    );
`else
    modport master (
        output cfg_load, cfg_pattern, cfg_mask, cfg_len, overlap,
        output ser_valid, ser_in,
        input  seq_valid
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_mask, cfg_len, overlap,
        input  ser_valid, ser_in,
        output seq_valid
    );
`endif

endinterface

`default_nettype wire

// File: rtl/seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_prog
// Brief    : Programmable serial sequence detector with per-bit don't-care
//            mask and overlap control. Define SEQDET_CNT_EN for the
//            saturating match counter (cnt_clr / match_cnt).
// Revision : 1.0 - initial release
// ============================================================================

module seq_det_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
    parameter int                 DEF_LEN     = 7,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'h3E)
`ifdef SEQDET_CNT_EN
    ,
    parameter int                 CNT_W       = 8
`endif
) (
    input wire            clk,
    input wire            rst,
    seq_det_prog_if.slave bus
);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_def_len = LEN_W'(DEF_LEN);

    typedef enum logic [0:0] {
        ST_FILLING = 1'b0,
        ST_ARMED   = 1'b1
    } state_t;

    logic [MAX_LEN-1:0] r_pat;
    logic [MAX_LEN-1:0] r_mask;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_fill;
    // The oldest history bit only matters in the incoming shifted view.
    logic [MAX_LEN-2:0] r_hist;
    state_t             r_state;
    logic               r_seq_valid;

    logic [MAX_LEN-1:0] w_hist_n;
    logic [MAX_LEN-1:0] w_lenmask;
    logic [MAX_LEN-1:0] w_diff;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [LEN_W-1:0]   w_cfg_len;
    logic               w_accept;
    logic               w_full;
    logic               w_match;

    always_comb begin
        w_cfg_len = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            w_cfg_len = LEN_W'(1);
        end else if (bus.cfg_len > c_max_len) begin
            w_cfg_len = c_max_len;
        end
    end

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_lenmask
        assign w_lenmask[i] = (LEN_W'(i) < r_len);
    end

    assign w_hist_n   = {r_hist, bus.ser_in};
    assign w_fill_inc = (r_fill >= r_len) ? r_len : r_fill + 1'b1;
    assign w_accept   = bus.ser_valid && !bus.cfg_load;
    assign w_full     = (r_state == ST_ARMED) || (w_fill_inc == r_len);
    assign w_diff     = (w_hist_n ^ r_pat) & r_mask & w_lenmask;
    assign w_match    = w_accept && w_full && (w_diff == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat       <= DEF_PATTERN;
            r_mask      <= '1;
            r_len       <= c_def_len;
            r_hist      <= '0;
            r_fill      <= '0;
            r_state     <= ST_FILLING;
            r_seq_valid <= 1'b0;
        end else if (bus.cfg_load) begin
            r_pat       <= bus.cfg_pattern;
            r_mask      <= bus.cfg_mask;
            r_len       <= w_cfg_len;
            r_hist      <= '0;
            r_fill      <= '0;
            r_state     <= ST_FILLING;
            r_seq_valid <= 1'b0;
        end else begin
            r_seq_valid <= w_match;
            if (bus.ser_valid) begin
                r_hist <= w_hist_n[MAX_LEN-2:0];
                // Non-overlap matches restart the fill so the next match needs len fresh bits.
                if (w_match && !bus.overlap) begin
                    r_fill  <= '0;
                    r_state <= ST_FILLING;
                end else begin
                    r_fill <= w_fill_inc;
                    if (w_full) begin
                        r_state <= ST_ARMED;
                    end
                end
            end
        end
    end

    assign bus.seq_valid = r_seq_valid;

`ifdef SEQDET_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.match_cnt = r_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_prog
// Brief    : Self-checking bench for seq_det_prog: queue-based reference model
//            plus directed streams with literal pulse expectations.
// Revision : 1.0 - initial release
// ============================================================================

module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
`ifdef SEQDET_CNT_EN
    localparam int CNT_W   = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_det_prog_if #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
`ifdef SEQDET_CNT_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) bus ();

    seq_det_prog #(
        .MAX_LEN    (MAX_LEN),
        .LEN_W      (LEN_W),
        .DEF_LEN    (7),
        .DEF_PATTERN(8'h3E)
`ifdef SEQDET_CNT_EN
        ,
        .CNT_W      (CNT_W)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the accepted bits since the last clear and
    // compares the newest len bits against the pattern (bit 0 = newest).
    int                 m_len   = 7;
    logic [MAX_LEN-1:0] m_pat   = 8'h3E;
    logic [MAX_LEN-1:0] m_mask  = 8'hFF;
    bit                 m_bits[$];
    bit                 m_hit;
    logic               exp_valid = 1'b0;
    int                 exp_cnt   = 0;

    always @(posedge clk or posedge rst) begin
        m_hit = 1'b0;
        if (rst) begin
            m_len  = 7;
            m_pat  = 8'h3E;
            m_mask = 8'hFF;
            m_bits.delete();
            exp_cnt = 0;
        end else begin
            if (bus.cfg_load) begin
                m_len  = (bus.cfg_len == 0) ? 1 :
                         (int'(bus.cfg_len) > MAX_LEN) ? MAX_LEN : int'(bus.cfg_len);
                m_pat  = bus.cfg_pattern;
                m_mask = bus.cfg_mask;
                m_bits.delete();
            end else if (bus.ser_valid) begin
                m_bits.push_back(bus.ser_in);
                if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                if (m_bits.size() >= m_len) begin
                    m_hit = 1'b1;
                    for (int k = 0; k < m_len; k++) begin
                        if (m_mask[k] && (m_bits[m_bits.size() - 1 - k] != m_pat[k])) m_hit = 1'b0;
                    end
                end
                if (m_hit && !bus.overlap) m_bits.delete();
            end
`ifdef SEQDET_CNT_EN
            if (bus.cnt_clr) exp_cnt = 0;
            else if (m_hit && exp_cnt < (2 ** CNT_W) - 1) exp_cnt++;
`endif
        end
        exp_valid = m_hit;
    end

    always @(negedge clk) begin
        check("seq_valid_vs_model", bus.seq_valid, exp_valid);
`ifdef SEQDET_CNT_EN
        check("match_cnt_vs_model", bus.match_cnt, exp_cnt);
`endif
    end

    // All stimulus tasks start and end just after a falling edge.
    task automatic send(input logic b, input logic exp, input string name);
        bus.ser_valid = 1'b1;
        bus.ser_in    = b;
        @(posedge clk); #1;
        check(name, bus.seq_valid, exp);
        @(negedge clk);
        bus.ser_valid = 1'b0;
    endtask

    // bits/pulses are written first-received on the left.
    task automatic stream(input string name, input logic [15:0] bits, input logic [15:0] pulses, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i], pulses[i], name);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("gap_no_pulse", bus.seq_valid, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic load(input logic [LEN_W-1:0] len, input logic [MAX_LEN-1:0] pat, input logic [MAX_LEN-1:0] mask);
        bus.cfg_load    = 1'b1;
        bus.cfg_len     = len;
        bus.cfg_pattern = pat;
        bus.cfg_mask    = mask;
        @(posedge clk); #1;
        check("load_clears_pulse", bus.seq_valid, 1'b0);
        @(negedge clk);
        bus.cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_async_clear", bus.seq_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_mask    = '0;
        bus.cfg_len     = '0;
        bus.overlap     = 1'b1;
        bus.ser_valid   = 1'b0;
        bus.ser_in      = 1'b0;
`ifdef SEQDET_CNT_EN
        bus.cnt_clr     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_seq_valid", bus.seq_valid, 1'b0);
`ifdef SEQDET_CNT_EN
        check("reset_match_cnt", bus.match_cnt, 0);
`endif
        rst = 1'b0;

        // Default flag with shared 0 between back-to-back flags.
        stream("default_flags", 16'b0111110111110, 16'b0000001000001, 13);

        // len=3, pattern 101, overlap on/off.
        load(4'd3, 8'b101, 8'b111);
        stream("p101_overlap", 16'b10101, 16'b00101, 5);
        bus.overlap = 1'b0;
        load(4'd3, 8'b101, 8'b111);
        stream("p101_nonoverlap", 16'b10101, 16'b00100, 5);
        load(4'd3, 8'b101, 8'b111);
        stream("p101_nonoverlap_2", 16'b101101, 16'b001001, 6);

        // Overlap switched off mid-stream: only later matches are affected.
        bus.overlap = 1'b1;
        load(4'd3, 8'b101, 8'b111);
        stream("ovl_switch_a", 16'b101, 16'b001, 3);
        bus.overlap = 1'b0;
        stream("ovl_switch_b", 16'b0101, 16'b0100, 4);
        bus.overlap = 1'b1;

        // Masked bit (second received) is don't-care.
        load(4'd4, 8'b1001, 8'b1011);
        stream("mask_1001", 16'b1001, 16'b0001, 4);
        load(4'd4, 8'b1001, 8'b1011);
        stream("mask_1101", 16'b1101, 16'b0001, 4);
        load(4'd4, 8'b1001, 8'b1011);
        stream("mask_1000", 16'b1000, 16'b0000, 4);

        // Default pattern with a ser_valid gap.
        do_reset();
        stream("gap_head", 16'b0111, 16'b0000, 4);
        idle(3);
        stream("gap_tail", 16'b110, 16'b001, 3);

        // Reset mid-pattern discards the partial match.
        stream("rst_partial", 16'b01111, 16'b00000, 5);
        do_reset();
        stream("rst_after", 16'b10, 16'b00, 2);
        stream("rst_full", 16'b0111110, 16'b0000001, 7);

        // Length clamping.
        load(4'd0, 8'h01, 8'h01);
        stream("len0_as_1", 16'b101, 16'b101, 3);
        load(4'd15, 8'hA5, 8'hFF);
        stream("len_clamp_hit", 16'b10100101, 16'b00000001, 8);
        load(4'd15, 8'hA5, 8'hFF);
        stream("len_clamp_msb", 16'b00100101, 16'b00000000, 8);

        // All-zero mask.
        load(4'd3, 8'h00, 8'h00);
        stream("zero_mask_ovl", 16'b0110, 16'b0011, 4);
        bus.overlap = 1'b0;
        load(4'd3, 8'h00, 8'h00);
        stream("zero_mask_nonovl", 16'b011010, 16'b001001, 6);
        bus.overlap = 1'b1;

        // ser_valid is ignored during cfg_load.
        bus.ser_valid = 1'b1;
        bus.ser_in    = 1'b1;
        load(4'd1, 8'h01, 8'h01);
        send(1'b1, 1'b1, "after_load_valid");

`ifdef SEQDET_CNT_EN
        bus.cnt_clr = 1'b1;
        idle(1);
        bus.cnt_clr = 1'b0;
        check("cnt_cleared", bus.match_cnt, 0);
        stream("cnt_five", 16'b11111, 16'b11111, 5);
        check("cnt_saturated", bus.match_cnt, 3);
        bus.cnt_clr = 1'b1;
        send(1'b1, 1'b1, "cnt_clr_with_match");
        bus.cnt_clr = 1'b0;
        check("cnt_clr_wins", bus.match_cnt, 0);
        send(1'b1, 1'b1, "cnt_next_match");
        check("cnt_after_clr", bus.match_cnt, 1);
        load(4'd1, 8'h01, 8'h01);
        check("cnt_kept_on_load", bus.match_cnt, 1);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
